// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the ZINDAN-1 core.
// Arbitrates the single-port memory between fetch and data access and drives datapath enables.
module multicycle_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [6:0]  opcode_i,
  input  logic        mem_ready_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_sel_data_o,
  output logic        ir_load_o,
  output logic        pc_inc_o,
  output logic [1:0]  alu_op_o,
  output logic        alu_src_o,
  output logic        mem_to_reg_o,
  output logic        reg_write_o,
  output logic        illegal_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic [2:0]  state_o,
  output logic [15:0] instr_count_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StHalt   = 3'd6,
    StFault  = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    ClsR  = 2'd0,
    ClsLd = 2'd1,
    ClsSt = 2'd2
  } cls_e;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpHalt = 7'b1111111;

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [15:0]       count_q, count_d;
  logic              start_ok_q;

  logic op_r, op_ld, op_st, op_halt, op_legal;
  logic mem_phase, mem_wait, timeout;

  assign op_r     = (opcode_i == OpR);
  assign op_ld    = (opcode_i == OpLd);
  assign op_st    = (opcode_i == OpSt);
  assign op_halt  = (opcode_i == OpHalt);
  assign op_legal = op_r | op_ld | op_st | op_halt;

  assign mem_phase = (state_q == StFetch) || (state_q == StMem);
  assign mem_wait  = mem_phase && !mem_ready_i;
  // Counter sits at the limit on the last tolerated cycle; one more miss faults.
  assign timeout   = mem_wait && (wait_q == WaitLimit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cls_q      <= ClsR;
      wait_q     <= '0;
      count_q    <= '0;
      start_ok_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cls_q      <= cls_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      start_ok_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    count_d = count_q;
    unique case (state_q)
      // start on the first edge after reset release is deliberately ignored
      StIdle:   if (start_i && start_ok_q) state_d = StFetch;
      StFetch: begin
        if (mem_ready_i)  state_d = StDecode;
        else if (timeout) state_d = StFault;
      end
      StDecode: begin
        if (op_r) begin
          cls_d   = ClsR;
          state_d = StExec;
        end else if (op_ld) begin
          cls_d   = ClsLd;
          state_d = StExec;
        end else if (op_st) begin
          cls_d   = ClsSt;
          state_d = StExec;
        end else if (op_halt) begin
          state_d = StHalt;
        end else begin
          state_d = StFetch;
        end
      end
      StExec:   state_d = (cls_q == ClsR) ? StWb : StMem;
      StMem: begin
        if (mem_ready_i) begin
          if (cls_q == ClsSt) begin
            state_d = StFetch;
            count_d = count_q + 16'd1;
          end else begin
            state_d = StWb;
          end
        end else if (timeout) begin
          state_d = StFault;
        end
      end
      StWb: begin
        state_d = StFetch;
        count_d = count_q + 16'd1;
      end
      StHalt:   state_d = StHalt;
      StFault:  state_d = StFault;
    endcase
  end

  // Any state change clears the wait counter, which covers every entry to FETCH and MEM.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_wait) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_comb begin
    mem_req_o      = 1'b0;
    mem_we_o       = 1'b0;
    mem_sel_data_o = 1'b0;
    ir_load_o      = 1'b0;
    pc_inc_o       = 1'b0;
    alu_op_o       = 2'b00;
    alu_src_o      = 1'b0;
    mem_to_reg_o   = 1'b0;
    reg_write_o    = 1'b0;
    illegal_o      = 1'b0;
    halted_o       = 1'b0;
    fault_o        = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req_o = 1'b1;
        ir_load_o = mem_ready_i;
        pc_inc_o  = mem_ready_i;
      end
      StDecode: illegal_o = !op_legal;
      StExec: begin
        alu_op_o  = (cls_q == ClsR) ? 2'b10 : 2'b00;
        alu_src_o = (cls_q != ClsR);
      end
      StMem: begin
        mem_req_o      = 1'b1;
        mem_sel_data_o = 1'b1;
        mem_we_o       = (cls_q == ClsSt);
        alu_op_o       = (cls_q == ClsR) ? 2'b10 : 2'b00;
        alu_src_o      = (cls_q != ClsR);
      end
      StWb: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (cls_q == ClsLd);
        alu_op_o     = (cls_q == ClsR) ? 2'b10 : 2'b00;
        alu_src_o    = (cls_q != ClsR);
      end
      StHalt:  halted_o = 1'b1;
      StFault: fault_o  = 1'b1;
      default: ;
    endcase
  end

  assign state_o       = state_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Self-checking bench for multicycle_sequencer: directed scenarios plus a randomized
// instruction stream checked against a per-instruction cycle model.
module tb_multicycle_sequencer;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_HALT = 7'b1111111;
  localparam logic [6:0] OP_ILL  = 7'b0010011;

  logic        clk, rst_n, start, mem_ready;
  logic [6:0]  opcode;
  logic        mem_req, mem_we, mem_sel_data, ir_load, pc_inc;
  logic [1:0]  alu_op;
  logic        alu_src, mem_to_reg, reg_write, illegal, halted, fault;
  logic [2:0]  state;
  logic [15:0] instr_count;
  logic [31:0] obs;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] exp;
    logic        rdy;
    logic        stt;
    logic [6:0]  opc;
  } slot_t;

  multicycle_sequencer #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .opcode_i      (opcode),
    .mem_ready_i   (mem_ready),
    .mem_req_o     (mem_req),
    .mem_we_o      (mem_we),
    .mem_sel_data_o(mem_sel_data),
    .ir_load_o     (ir_load),
    .pc_inc_o      (pc_inc),
    .alu_op_o      (alu_op),
    .alu_src_o     (alu_src),
    .mem_to_reg_o  (mem_to_reg),
    .reg_write_o   (reg_write),
    .illegal_o     (illegal),
    .halted_o      (halted),
    .fault_o       (fault),
    .state_o       (state),
    .instr_count_o (instr_count)
  );

  assign obs = {state, mem_req, mem_we, mem_sel_data, ir_load, pc_inc, alu_op, alu_src,
                mem_to_reg, reg_write, illegal, halted, fault, instr_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs just after the falling edge, then let combinational outputs settle.
  task automatic cyc(input logic s, input logic r, input logic [6:0] o);
    @(negedge clk);
    start     = s;
    mem_ready = r;
    opcode    = o;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    rst_n     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Expected output vector in the same field order as obs.
  function automatic logic [31:0] mk(input logic [2:0] st, input logic req, input logic we,
                                     input logic sel, input logic irl, input logic [1:0] aop,
                                     input logic src, input logic m2r, input logic rw,
                                     input logic ill, input logic [15:0] cnt);
    return {st, req, we, sel, irl, irl, aop, src, m2r, rw, ill, 1'b0, 1'b0, cnt};
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 32'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 00000000", obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    cyc(1'b1, 1'b0, 7'd0);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL start_at_release: got state %0d want 0", state);
    end
    cyc(1'b0, 1'b0, 7'd0);
    total++;
    if (state !== 3'd1) begin
      bad++;
      $display("FAIL start_after_release: got state %0d want 1", state);
    end
  endtask

  task automatic test_rtype();
    logic [2:0] exp_st [5];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    total++;
    if (state !== 3'd0) begin
      bad++;
      $display("FAIL rtype_idle: got state %0d want 0", state);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 1'b1, OP_R);
      total++;
      if (state !== exp_st[i]) begin
        bad++;
        $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      total++;
      if (reg_write !== (exp_st[i] == 3'd5)) begin
        bad++;
        $display("FAIL rtype_reg_write[%0d]: got %0b", i, reg_write);
      end
      total++;
      if (alu_op !== ((exp_st[i] == 3'd3 || exp_st[i] == 3'd5) ? 2'b10 : 2'b00)) begin
        bad++;
        $display("FAIL rtype_alu_op[%0d]: got %b in state %0d", i, alu_op, exp_st[i]);
      end
      total++;
      if ({ir_load, pc_inc} !== {2{exp_st[i] == 3'd1}}) begin
        bad++;
        $display("FAIL rtype_fetch_strobes[%0d]: got %b", i, {ir_load, pc_inc});
      end
    end
    total++;
    if (instr_count !== 16'd1) begin
      bad++;
      $display("FAIL rtype_count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_load();
    logic [2:0] exp_st [8];
    logic       rdy    [8];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
    rdy    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 8; i++) begin
      // opcode only matters in DECODE; other cycles carry R-type to prove the class is latched
      cyc(1'b0, rdy[i], (i == 1) ? OP_LD : OP_R);
      total++;
      if (state !== exp_st[i]) begin
        bad++;
        $display("FAIL load_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      if (exp_st[i] == 3'd4) begin
        total++;
        if ({mem_req, mem_sel_data, mem_we} !== 3'b110) begin
          bad++;
          $display("FAIL load_mem_ctl[%0d]: got %b want 110", i, {mem_req, mem_sel_data, mem_we});
        end
      end
      total++;
      if ({mem_to_reg, reg_write} !== {2{exp_st[i] == 3'd5}}) begin
        bad++;
        $display("FAIL load_wb[%0d]: got %b", i, {mem_to_reg, reg_write});
      end
      total++;
      if (instr_count !== ((i == 7) ? 16'd1 : 16'd0)) begin
        bad++;
        $display("FAIL load_count[%0d]: got %0d", i, instr_count);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0] exp_st [5];
    logic       rdy    [5];
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1};
    rdy    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, rdy[i], (i == 1) ? OP_ST : 7'($urandom));
      total++;
      if (state !== exp_st[i]) begin
        bad++;
        $display("FAIL store_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
      total++;
      if ({mem_we, reg_write} !== {exp_st[i] == 3'd4, 1'b0}) begin
        bad++;
        $display("FAIL store_we_rw[%0d]: got %b", i, {mem_we, reg_write});
      end
      total++;
      if (instr_count !== ((i == 4) ? 16'd1 : 16'd0)) begin
        bad++;
        $display("FAIL store_count[%0d]: got %0d", i, instr_count);
      end
    end
  endtask

  task automatic test_halt();
    logic [2:0] exp_st [3];
    exp_st = '{3'd1, 3'd2, 3'd6};
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, (i == 0), OP_HALT);
      total++;
      if (state !== exp_st[i]) begin
        bad++;
        $display("FAIL halt_state[%0d]: got %0d want %0d", i, state, exp_st[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 7'($urandom));
      total++;
      if ({state, halted, mem_req, mem_we, ir_load, pc_inc, reg_write, instr_count} !==
          {3'd6, 1'b1, 5'b0, 16'd0}) begin
        bad++;
        $display("FAIL halt_hold[%0d]: got state %0d halted %0b req %0b cnt %0d want 6 1 0 0",
                 i, state, halted, mem_req, instr_count);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, OP_R);
      total++;
      if (state !== 3'd1) begin
        bad++;
        $display("FAIL timeout_fetch[%0d]: got state %0d want 1", i, state);
      end
    end
    cyc(1'b0, 1'b1, OP_R);
    total++;
    if ({state, fault, mem_req} !== {3'd7, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL timeout_fault: got state %0d fault %0b req %0b want 7 1 0",
               state, fault, mem_req);
    end
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, (i == 3), OP_R);
      total++;
      if (state !== 3'd1) begin
        bad++;
        $display("FAIL limit_fetch[%0d]: got state %0d want 1", i, state);
      end
    end
    cyc(1'b0, 1'b0, OP_R);
    total++;
    if ({state, fault} !== {3'd2, 1'b0}) begin
      bad++;
      $display("FAIL limit_ready: got state %0d fault %0b want 2 0", state, fault);
    end
  endtask

  task automatic test_illegal();
    logic [2:0] exp_st [3];
    exp_st = '{3'd1, 3'd2, 3'd1};
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, (i == 0), OP_ILL);
      total++;
      if ({state, illegal} !== {exp_st[i], i == 1}) begin
        bad++;
        $display("FAIL illegal[%0d]: got state %0d illegal %0b", i, state, illegal);
      end
    end
    total++;
    if (instr_count !== 16'd0) begin
      bad++;
      $display("FAIL illegal_count: got %0d want 0", instr_count);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    cyc(1'b1, 1'b0, OP_R);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, OP_R);
    cyc(1'b0, 1'b1, OP_LD);
    cyc(1'b0, 1'b0, OP_LD);
    cyc(1'b0, 1'b0, OP_LD);
    cyc(1'b0, 1'b0, OP_LD);
    total++;
    if ({state, mem_req, instr_count} !== {3'd4, 1'b1, 16'd1}) begin
      bad++;
      $display("FAIL pre_reset_mem: got state %0d req %0b cnt %0d want 4 1 1",
               state, mem_req, instr_count);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== 32'd0) begin
      bad++;
      $display("FAIL async_reset_outputs: got %h want 00000000", obs);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, OP_LD);
    total++;
    if ({state, instr_count} !== {3'd0, 16'd0}) begin
      bad++;
      $display("FAIL post_reset: got state %0d cnt %0d want 0 0", state, instr_count);
    end
  endtask

  task automatic test_random();
    slot_t       q[$];
    slot_t       s;
    logic [15:0] mc;
    int          k, wf, wm;
    logic [6:0]  op;
    logic [1:0]  aop;
    logic        src;
    mc    = 16'd0;
    s.exp = mk(3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, mc);
    s.rdy = 1'($urandom_range(0, 1));
    s.stt = 1'b1;
    s.opc = 7'($urandom);
    q.push_back(s);
    for (int n = 0; n < 150; n++) begin
      k  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      wf = int'($urandom_range(0, 3));
      wm = int'($urandom_range(0, 3));
      case (k)
        0:       op = OP_R;
        1:       op = OP_LD;
        2:       op = OP_ST;
        default: begin
          op = 7'($urandom);
          while (op == OP_R || op == OP_LD || op == OP_ST || op == OP_HALT) op = 7'($urandom);
        end
      endcase
      aop = (k == 0) ? 2'b10 : 2'b00;
      src = (k == 1 || k == 2);
      for (int i = 0; i <= wf; i++) begin
        s.rdy = (i == wf);
        s.stt = 1'($urandom_range(0, 1));
        s.opc = 7'($urandom);
        s.exp = mk(3'd1, 1'b1, 1'b0, 1'b0, s.rdy, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, mc);
        q.push_back(s);
      end
      s.rdy = 1'($urandom_range(0, 1));
      s.opc = op;
      s.exp = mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, k == 3, mc);
      q.push_back(s);
      if (k == 3) continue;
      s.rdy = 1'($urandom_range(0, 1));
      s.opc = 7'($urandom);
      s.exp = mk(3'd3, 1'b0, 1'b0, 1'b0, 1'b0, aop, src, 1'b0, 1'b0, 1'b0, mc);
      q.push_back(s);
      if (k != 0) begin
        for (int i = 0; i <= wm; i++) begin
          s.rdy = (i == wm);
          s.opc = 7'($urandom);
          s.exp = mk(3'd4, 1'b1, k == 2, 1'b1, 1'b0, aop, src, 1'b0, 1'b0, 1'b0, mc);
          q.push_back(s);
        end
      end
      if (k == 2) begin
        mc++;
      end else begin
        s.rdy = 1'($urandom_range(0, 1));
        s.opc = 7'($urandom);
        s.exp = mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, aop, src, k == 1, 1'b1, 1'b0, mc);
        q.push_back(s);
        mc++;
      end
    end
    do_reset();
    foreach (q[i]) begin
      cyc(q[i].stt, q[i].rdy, q[i].opc);
      total++;
      if (obs !== q[i].exp) begin
        bad++;
        $display("FAIL random[%0d]: got %h want %h", i, obs, q[i].exp);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 7'd0;
    test_reset();
    test_rtype();
    test_load();
    test_store();
    test_halt();
    test_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
